// File: rtl/bcd_pkg.sv
// Shared constants for BCD 7-segment display users.
package bcd_pkg;

  // Segment patterns are active-low and packed as {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Scan FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-BCD codes (10..15) render as a dash; blank overrides everything.
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins, then dash for invalid codes, then table lookup.
  always_comb begin
    seg = SEG_BLANK;
    if (blank)            seg = SEG_BLANK;
    else if (bcd > 4'd9)  seg = SEG_DASH;
    else                  seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode display driver. Digits are snapshotted at
// the start of every frame; each digit is lit for DWELL cycles and followed
// by GAP dark cycles. Outputs are registered one stage after the FSM.
module bcd_scan_display
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int GAP        = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int MAXV = (DWELL > GAP) ? DWELL : GAP;
  localparam int TW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] DW_LAST  = TW'(DWELL - 1);
  localparam logic [TW-1:0] GP_LAST  = TW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = '1;
  localparam logic [NUM_DIGITS-1:0] ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           timer;
  logic [4*NUM_DIGITS-1:0] snap_bcd;
  logic [NUM_DIGITS-1:0]   snap_dp;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;

  // Leading-zero mask: walk down from the top digit while all seen are zero.
  // Digit 0 is never blanked; a dash nibble is non-zero and stops the run.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run && (snap_bcd[k*4 +: 4] == 4'd0);
      blank_mask[k] = blank_lz && (k != 0) && zero_run;
    end
  end

  assign cur_nib = snap_bcd[idx*4 +: 4];

  bcd_to_seg7 u_dec (
    .bcd   (cur_nib),
    .blank (blank_mask[idx]),
    .seg   (cur_seg)
  );

  // Scan FSM: snapshot on frame start, dwell/gap timing, digit advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      timer      <= '0;
      snap_bcd   <= '0;
      snap_dp    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        idx   <= '0;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_SHOW;
            idx        <= '0;
            timer      <= '0;
            snap_bcd   <= bcd_in;
            snap_dp    <= dp_in;
            frame_tick <= 1'b1;
          end
          ST_SHOW: begin
            if (timer == DW_LAST) begin
              state <= ST_GAP;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_GAP: begin
            if (timer == GP_LAST) begin
              state <= ST_SHOW;
              timer <= '0;
              if (idx == IDX_LAST) begin
                idx        <= '0;
                snap_bcd   <= bcd_in;
                snap_dp    <= dp_in;
                frame_tick <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            idx   <= '0;
            timer <= '0;
          end
        endcase
      end
    end
  end

  // Output stage: lit only while SHOW; enable gating darkens the very next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
      digit_en <= EN_OFF;
    end else if (enable && state == ST_SHOW) begin
      seg      <= cur_seg;
      dp       <= ~snap_dp[idx];
      digit_en <= ~(ONE << idx);
    end else begin
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
      digit_en <= EN_OFF;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with NUM_DIGITS=4, DWELL=4, GAP=2.
module tb_bcd_scan_display;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        blank_lz;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, SD = 7'b0111111, SB = 7'b1111111;

  bcd_scan_display #(.NUM_DIGITS(4), .DWELL(4), .GAP(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  // Checks nmax cycles following a frame_tick cycle. Digit k is lit at
  // n = 1+6k .. 4+6k, dark at 5+6k, 6+6k; the next frame_tick is at n=24.
  task automatic check_frame(input string name, input logic [3:0][6:0] es,
                             input logic [3:0] edp, input int nmax,
                             input int chg_n, input logic [15:0] chg_val);
    int k, ph;
    logic lit;
    logic [3:0] x_en;
    logic [6:0] x_seg;
    logic x_dp, x_ft;
    for (int n = 1; n <= nmax; n++) begin
      @(negedge clock);
      k = (n - 1) / 6;
      ph = (n - 1) % 6;
      lit = (ph < 4);
      x_en = lit ? ~(4'b0001 << k) : 4'hF;
      x_seg = lit ? es[k] : SB;
      x_dp = lit ? ~edp[k] : 1'b1;
      x_ft = (n == 24);
      checks++;
      if ({digit_en, seg, dp, frame_tick} !== {x_en, x_seg, x_dp, x_ft}) begin
        errors++;
        $display("FAIL %s n=%0d: got en=%b seg=%b dp=%b ft=%b, want en=%b seg=%b dp=%b ft=%b",
                 name, n, digit_en, seg, dp, frame_tick, x_en, x_seg, x_dp, x_ft);
      end
      if (n == chg_n) bcd_in = chg_val;
    end
  endtask

  // Go dark, load new inputs, re-enable and expect the start-of-frame pulse.
  task automatic start_scan(input string name, input logic [15:0] b,
                            input logic blz, input logic [3:0] d);
    enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bcd_in = b;
    blank_lz = blz;
    dp_in = d;
    enable = 1'b1;
    @(negedge clock);
    checks++;
    if (frame_tick !== 1'b1 || digit_en !== 4'hF) begin
      errors++;
      $display("FAIL %s_start: got ft=%b en=%b, want ft=1 en=1111", name, frame_tick, digit_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; blank_lz = 1'b0; bcd_in = '0; dp_in = '0;
    #1;
    checks++;
    if ({digit_en, seg, dp, frame_tick} !== {4'hF, SB, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got en=%b seg=%b dp=%b ft=%b", digit_en, seg, dp, frame_tick);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({digit_en, seg, dp, frame_tick} !== {4'hF, SB, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL idle_dark c=%0d: got en=%b seg=%b dp=%b ft=%b, want dark",
                 i, digit_en, seg, dp, frame_tick);
      end
    end
  endtask

  task automatic test_scan();
    start_scan("scan", 16'h1234, 1'b0, 4'b0101);
    check_frame("scan_f1", {S1, S2, S3, S4}, 4'b0101, 24, 0, 16'h0);
    check_frame("scan_f2", {S1, S2, S3, S4}, 4'b0101, 24, 0, 16'h0);
  endtask

  task automatic test_blanking();
    start_scan("lz7", 16'h0007, 1'b1, 4'b0000);
    check_frame("lz7", {SB, SB, SB, S7}, 4'b0000, 24, 0, 16'h0);
    start_scan("lz0", 16'h0000, 1'b1, 4'b0010);
    check_frame("lz0", {SB, SB, SB, S0}, 4'b0010, 24, 0, 16'h0);
    start_scan("lzA", 16'h0A05, 1'b1, 4'b0000);
    check_frame("lzA", {SB, SD, S0, S5}, 4'b0000, 24, 0, 16'h0);
  endtask

  task automatic test_snapshot();
    start_scan("snap", 16'h1111, 1'b0, 4'b0000);
    check_frame("snap_old", {S1, S1, S1, S1}, 4'b0000, 24, 8, 16'h2222);
    check_frame("snap_new", {S2, S2, S2, S2}, 4'b0000, 24, 0, 16'h0);
  endtask

  task automatic test_async_reset();
    start_scan("rst", 16'h1234, 1'b0, 4'b0000);
    check_frame("rst_pre", {S1, S2, S3, S4}, 4'b0000, 2, 0, 16'h0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({digit_en, seg, dp, frame_tick} !== {4'hF, SB, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got en=%b seg=%b dp=%b ft=%b, want dark",
               digit_en, seg, dp, frame_tick);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (frame_tick !== 1'b1 || digit_en !== 4'hF) begin
      errors++;
      $display("FAIL rst_restart: got ft=%b en=%b, want ft=1 en=1111", frame_tick, digit_en);
    end
    check_frame("rst_post", {S1, S2, S3, S4}, 4'b0000, 24, 0, 16'h0);
  endtask

  task automatic test_enable_drop();
    start_scan("en", 16'h1234, 1'b0, 4'b0000);
    check_frame("en_pre", {S1, S2, S3, S4}, 4'b0000, 9, 0, 16'h0);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({digit_en, seg, dp, frame_tick} !== {4'hF, SB, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL en_drop c=%0d: got en=%b seg=%b dp=%b ft=%b, want dark",
                 i, digit_en, seg, dp, frame_tick);
      end
    end
    enable = 1'b1;
    @(negedge clock);
    checks++;
    if (frame_tick !== 1'b1 || digit_en !== 4'hF) begin
      errors++;
      $display("FAIL en_restart: got ft=%b en=%b, want ft=1 en=1111", frame_tick, digit_en);
    end
    check_frame("en_post", {S1, S2, S3, S4}, 4'b0000, 24, 0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_snapshot();
    test_async_reset();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
